// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single dma port between the instruction-fetch path
// and the load/store path. One transaction at a time, req/ready handshake per
// requester, data has priority over fetch.
// Optional build macro ARB_FAIR_EN: after MAX_DATA_STREAK consecutive data
// grants while fetch is waiting, the next grant goes to fetch.
module mem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int TIMEOUT         = 1023,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ready,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [DATA_W-1:0] dma_wdata,
    output logic              dma_we,
    output logic [3:0]        dma_be,
    output logic              dma_start,
    input  logic [DATA_W-1:0] dma_rdata,
    input  logic              dma_busy,
    output logic [1:0]        grant,
    output logic              err
);

`ifdef ARB_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [DATA_W-1:0]   ABORT_WORD = DATA_W'(32'hDEADBEEF);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t              state;
    logic [TMO_W-1:0]    tmo_cnt;
    logic                wait_cnt;
    logic [STREAK_W-1:0] streak;

    logic                pick_data;
    logic                complete;
    logic                timed_out;
    logic [DATA_W-1:0]   resp_data;

    // Arbitration choice: data wins unless fetch has waited out a full data streak
    always_comb begin
        pick_data = d_req && !(FAIR_EN && f_req && (streak == STREAK_MAX));
    end

    // Detect end of the current transaction (normal, zero-latency or timeout)
    always_comb begin
        complete  = 1'b0;
        timed_out = 1'b0;
        resp_data = dma_rdata;
        case (state)
            WAIT_BUSY: complete = !dma_busy && wait_cnt;
            WAIT_DONE: begin
                if (!dma_busy) begin
                    complete = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    resp_data = ABORT_WORD;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM with registered dma and requester outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            wait_cnt  <= 1'b0;
            streak    <= '0;
            f_ready   <= 1'b0;
            f_rdata   <= '0;
            d_ready   <= 1'b0;
            d_rdata   <= '0;
            dma_addr  <= '0;
            dma_wdata <= '0;
            dma_we    <= 1'b0;
            dma_be    <= 4'b0000;
            dma_start <= 1'b0;
            grant     <= 2'b00;
            err       <= 1'b0;
        end else begin
            dma_start <= 1'b0;
            f_ready   <= 1'b0;
            d_ready   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!dma_busy && (d_req || f_req)) begin
                        if (pick_data) begin
                            grant     <= 2'b10;
                            dma_addr  <= d_addr;
                            dma_wdata <= d_wdata;
                            dma_we    <= d_we;
                            dma_be    <= d_be;
                            if (FAIR_EN) begin
                                if (!f_req) begin
                                    streak <= '0;
                                end else if (streak != STREAK_MAX) begin
                                    streak <= streak + 1'b1;
                                end
                            end
                        end else begin
                            grant     <= 2'b01;
                            dma_addr  <= f_addr;
                            dma_wdata <= '0;
                            dma_we    <= 1'b0;
                            dma_be    <= 4'b0000;
                            if (FAIR_EN) begin
                                streak <= '0;
                            end
                        end
                        dma_start <= 1'b1;
                        wait_cnt  <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (dma_busy) begin
                        state <= WAIT_DONE;
                    end else if (!wait_cnt) begin
                        wait_cnt <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (dma_busy && !timed_out) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    grant     <= 2'b00;
                    dma_addr  <= '0;
                    dma_wdata <= '0;
                    dma_we    <= 1'b0;
                    dma_be    <= 4'b0000;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (timed_out) begin
                err <= 1'b1;
            end

            if (complete) begin
                state <= RESP;
                if (grant == 2'b01) begin
                    f_ready <= 1'b1;
                    f_rdata <= resp_data;
                end else begin
                    d_ready <= 1'b1;
                    if (!dma_we) begin
                        d_rdata <= resp_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Stimulus pushes expected
// dma issues and requester responses into queues; a monitor pops and compares
// whenever dma_start or a ready pulse appears. A small dma model answers each
// dma_start with a programmable busy length.
module tb_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_we;
    logic [3:0]  dma_be;
    logic        dma_start;
    logic [31:0] dma_rdata;
    logic        dma_busy;
    logic [1:0]  grant;
    logic        err;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        int          gap;
    } issue_t;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } resp_t;

    issue_t issue_q[$];
    resp_t  resp_q[$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int          busy_len = 1;
    logic [31:0] dma_val  = 32'h0;

    mem_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ready   (f_ready),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_we    (dma_we),
        .dma_be    (dma_be),
        .dma_start (dma_start),
        .dma_rdata (dma_rdata),
        .dma_busy  (dma_busy),
        .grant     (grant),
        .err       (err)
    );

    // Free-running clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportFail(input string name, input int act, input int exp);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Simple dma: busy for busy_len cycles after dma_start, then present dma_val
    initial begin
        dma_busy  = 1'b0;
        dma_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (dma_start === 1'b1) begin
                #1;
                if (busy_len == 0) begin
                    dma_rdata = dma_val;
                end else begin
                    dma_busy = 1'b1;
                    repeat (busy_len) @(posedge clk);
                    #1;
                    dma_busy  = 1'b0;
                    dma_rdata = dma_val;
                end
            end
        end
    end

    // Monitor: compare every dma issue and every ready pulse against the queues
    initial begin
        issue_t      ie;
        resp_t       re;
        int          start_cyc = 0;
        int          ready_cyc = 0;
        logic [31:0] cur_addr  = 32'h0;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                if (dma_start === 1'b1) begin
                    if (issue_q.size() == 0) begin
                        reportFail("unexpected_dma_start", 1, 0);
                    end else begin
                        ie = issue_q.pop_front();
                        checkOutput("start_grant", {30'd0, grant}, {30'd0, ie.grant});
                        checkOutput("start_addr", dma_addr, ie.addr);
                        checkOutput("start_wdata", dma_wdata, ie.wdata);
                        checkOutput("start_we", {31'd0, dma_we}, {31'd0, ie.we});
                        checkOutput("start_be", {28'd0, dma_be}, {28'd0, ie.be});
                        if (ie.gap != 0) begin
                            checkOutput("start_gap", 32'(cyc - ready_cyc), 32'(ie.gap));
                        end
                        cur_addr  = ie.addr;
                        start_cyc = cyc;
                    end
                end
                if (f_ready === 1'b1 || d_ready === 1'b1) begin
                    if (resp_q.size() == 0) begin
                        reportFail("unexpected_ready", 1, 0);
                    end else begin
                        re = resp_q.pop_front();
                        checkOutput("ready_port", {30'd0, d_ready, f_ready},
                                    re.is_data ? 32'd2 : 32'd1);
                        checkOutput("rdata", re.is_data ? d_rdata : f_rdata, re.rdata);
                        checkOutput("err", {31'd0, err}, {31'd0, re.err});
                        checkOutput("hold_addr", dma_addr, cur_addr);
                        if (re.lat != 0) begin
                            checkOutput("latency", 32'(cyc - start_cyc), 32'(re.lat));
                        end
                    end
                    ready_cyc = cyc;
                end
            end
        end
    end

    task automatic expectTxn(input bit is_data, input bit we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input bit err_exp,
                             input int lat, input int gap);
        issue_t ie;
        resp_t  re;
        ie.grant   = is_data ? 2'b10 : 2'b01;
        ie.addr    = addr;
        ie.wdata   = is_data ? wdata : 32'h0;
        ie.we      = is_data ? we : 1'b0;
        ie.be      = is_data ? be : 4'b0000;
        ie.gap     = gap;
        re.is_data = is_data;
        re.rdata   = rdata;
        re.err     = err_exp;
        re.lat     = lat;
        issue_q.push_back(ie);
        resp_q.push_back(re);
    endtask

    task automatic applyStimulus(input bit is_data, input bit we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (is_data) begin
            d_we    = we;
            d_be    = be;
            d_addr  = addr;
            d_wdata = wdata;
            d_req   = 1'b1;
        end else begin
            f_addr = addr;
            f_req  = 1'b1;
        end
    endtask

    // Wait for n ready pulses; unless hold is set, each requester drops on its ready
    task automatic runUntil(input int n, input bit hold, input int budget);
        int seen   = 0;
        int cycles = 0;
        while (seen < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (f_ready === 1'b1) begin
                seen++;
                if (!hold) f_req = 1'b0;
            end
            if (d_ready === 1'b1) begin
                seen++;
                if (!hold) d_req = 1'b0;
            end
        end
        if (seen < n) reportFail("ready_timeout", seen, n);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_grant"}, {30'd0, grant}, 32'd0);
        checkOutput({tag, "_start"}, {31'd0, dma_start}, 32'd0);
        checkOutput({tag, "_ready"}, {30'd0, f_ready, d_ready}, 32'd0);
        checkOutput({tag, "_dma_addr"}, dma_addr, 32'd0);
        checkOutput({tag, "_dma_ctl"}, {27'd0, dma_we, dma_be}, 32'd0);
    endtask

    // Directed test sequence
    initial begin
        resetn  = 1'b0;
        f_req   = 1'b0;
        f_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'b0000;
        d_addr  = 32'h0;
        d_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_f_rdata", f_rdata, 32'd0);
        checkOutput("reset_d_rdata", d_rdata, 32'd0);
        checkOutput("reset_err", {31'd0, err}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single fetch, busy three cycles
        busy_len = 3;
        dma_val  = 32'h00000013;
        expectTxn(0, 0, 4'h0, 32'h00800010, 32'h0, 32'h00000013, 0, 5, 0);
        applyStimulus(0, 0, 4'h0, 32'h00800010, 32'h0);
        runUntil(1, 0, 40);
        @(negedge clk);
        checkIdleOutputs("after_fetch");

        // Load with one busy cycle: minimum latency
        busy_len = 1;
        dma_val  = 32'hCAFE0001;
        expectTxn(1, 0, 4'h0, 32'h20000008, 32'h0, 32'hCAFE0001, 0, 3, 0);
        applyStimulus(1, 0, 4'h0, 32'h20000008, 32'h0);
        runUntil(1, 0, 40);
        @(negedge clk);

        // Fetch where dma never raises busy: zero-latency completion
        busy_len = 0;
        dma_val  = 32'h00000093;
        expectTxn(0, 0, 4'h0, 32'h00800018, 32'h0, 32'h00000093, 0, 3, 0);
        applyStimulus(0, 0, 4'h0, 32'h00800018, 32'h0);
        runUntil(1, 0, 40);
        @(negedge clk);

        // Simultaneous store and fetch: store first, d_rdata keeps the last load
        busy_len = 2;
        dma_val  = 32'h00400513;
        expectTxn(1, 1, 4'hF, 32'h20000000, 32'hA5A5A5A5, 32'hCAFE0001, 0, 0, 0);
        expectTxn(0, 0, 4'h0, 32'h00800014, 32'h0, 32'h00400513, 0, 0, 2);
        applyStimulus(1, 1, 4'hF, 32'h20000000, 32'hA5A5A5A5);
        applyStimulus(0, 0, 4'h0, 32'h00800014, 32'h0);
        runUntil(2, 0, 60);
        @(negedge clk);
        d_we = 1'b0;
        d_be = 4'h0;

        // Reset while in WAIT_DONE with dma still busy
        busy_len = 8;
        dma_val  = 32'h11111111;
        begin
            issue_t ie;
            ie.grant = 2'b01;
            ie.addr  = 32'h00800030;
            ie.wdata = 32'h0;
            ie.we    = 1'b0;
            ie.be    = 4'h0;
            ie.gap   = 0;
            issue_q.push_back(ie);
        end
        applyStimulus(0, 0, 4'h0, 32'h00800030, 32'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        f_req  = 1'b0;
        @(negedge clk);
        checkIdleOutputs("midreset");
        checkOutput("midreset_f_rdata", f_rdata, 32'd0);
        checkOutput("midreset_d_rdata", d_rdata, 32'd0);
        resetn   = 1'b1;
        busy_len = 3;
        dma_val  = 32'h00000013;
        expectTxn(0, 0, 4'h0, 32'h00800010, 32'h0, 32'h00000013, 0, 5, 0);
        applyStimulus(0, 0, 4'h0, 32'h00800010, 32'h0);
        begin
            int guard = 0;
            while (dma_busy === 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
                if (dma_busy === 1'b1) begin
                    checkOutput("grant_while_busy", {30'd0, grant}, 32'd0);
                end
            end
            if (guard >= 20) reportFail("busy_drain_timeout", guard, 20);
        end
        runUntil(1, 0, 40);
        @(negedge clk);

        // Timeout: dma stays busy far past TIMEOUT
        busy_len = 1100;
        dma_val  = 32'h55555555;
        expectTxn(0, 0, 4'h0, 32'h00800020, 32'h0, 32'hDEADBEEF, 1, 0, 0);
        applyStimulus(0, 0, 4'h0, 32'h00800020, 32'h0);
        runUntil(1, 0, 1200);
        @(negedge clk);
        checkOutput("err_sticky_after_timeout", {31'd0, err}, 32'd1);
        begin
            int guard = 0;
            while (dma_busy === 1'b1 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) reportFail("timeout_busy_drain", guard, 200);
        end
        @(negedge clk);
        busy_len = 1;
        dma_val  = 32'h00000001;
        expectTxn(0, 0, 4'h0, 32'h00800024, 32'h0, 32'h00000001, 1, 3, 0);
        applyStimulus(0, 0, 4'h0, 32'h00800024, 32'h0);
        runUntil(1, 0, 40);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("err_cleared_by_reset", {31'd0, err}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Both requesters held: data priority, or streak-limited with ARB_FAIR_EN
        busy_len = 1;
        dma_val  = 32'h0BADF00D;
`ifdef ARB_FAIR_EN
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 0);
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 2);
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 2);
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 2);
        expectTxn(0, 0, 4'h0, 32'h00800100, 32'h0, 32'h0BADF00D, 0, 3, 2);
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 2);
`else
        expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 0);
        for (int i = 0; i < 5; i++) begin
            expectTxn(1, 0, 4'h0, 32'h20000040, 32'h0, 32'h0BADF00D, 0, 3, 2);
        end
`endif
        expectTxn(0, 0, 4'h0, 32'h00800100, 32'h0, 32'h0BADF00D, 0, 3, 2);
        applyStimulus(1, 0, 4'h0, 32'h20000040, 32'h0);
        applyStimulus(0, 0, 4'h0, 32'h00800100, 32'h0);
        runUntil(6, 1, 80);
        d_req = 1'b0;
        runUntil(1, 0, 40);
        repeat (3) @(negedge clk);

        // Everything expected must have been observed
        checkOutput("issue_queue_empty", 32'(issue_q.size()), 32'd0);
        checkOutput("resp_queue_empty", 32'(resp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
